// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch front-end with flushable response queue
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [31:0]            imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [31:0]            instr_o,
    output logic [31:0]            pc_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Stale (to-be-dropped) responses ride on top of the live credit window,
    // so the total in-flight count gets one extra bit of headroom.
    localparam int unsigned OW = CW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q [DEPTH];

    logic          req;
    logic          issue;
    logic          push;
    logic          pop;
    logic [OW-1:0] live_outstanding;
    logic [OW:0]   credit_used;
    logic [31:0]   redirect_target;

    // Credit check, handshake qualification and queue push/pop decisions
    always_comb begin
        live_outstanding = outstanding_q - drop_cnt_q;
        credit_used      = {1'b0, live_outstanding} + (OW+1)'(count_q);
        req              = (state_q != ST_IDLE) && (credit_used < (OW+1)'(DEPTH));
        issue            = req && imem_gnt_i;
        pop              = (count_q != '0) && instr_ready_i;
        push             = imem_rvalid_i && (drop_cnt_q == '0);
        redirect_target  = {redirect_pc_i[31:2], 2'b00};
    end

    // Next-state: redirect overrides everything, else normal fetch/queue bookkeeping
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + OW'(issue) - OW'(imem_rvalid_i);
        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = outstanding_d;
            if (state_q != ST_IDLE) begin
                state_d = (outstanding_d != '0) ? ST_FLUSH : ST_FETCH;
            end
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                ST_IDLE:  if (enable_i) state_d = ST_FETCH;
                ST_FLUSH: if (drop_cnt_d == '0) state_d = ST_FETCH;
                default:  state_d = state_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only observed through a valid head, so no reset
    always_ff @(posedge clk_i) begin
        if (push && !redirect_i) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // Memory-side protocol sanity checks
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && (count_q == CW'(DEPTH))));
            assert (!(imem_rvalid_i && (outstanding_q == '0)));
        end
    end

    // Output view: head entry is presented directly, zeroed when the queue is empty
    always_comb begin
        imem_req_o    = req;
        imem_addr_o   = fetch_pc_q;
        instr_valid_o = (count_q != '0);
        instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'd0;
        pc_o          = instr_valid_o ? fifo_pc_q[rd_ptr_q] : 32'd0;
        count_o       = count_q;
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic [2:0]  count;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc),
        .instr_ready_i(ready), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    pend_t       pend[$];
    ent_t        mq[$];
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];
    int          epoch = 0;
    int          cyc = 0;
    int          grants = 0;
    int          stale_cnt = 0;
    int          lat = 2;
    bit          gnt_en = 1'b1;
    bit          m_run = 1'b0;
    bit          started = 1'b0;
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] m_resp_pc = RESET_PC;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder plus reference model; compares DUT outputs every cycle
    always @(negedge clk) begin : model
        int    live;
        bit    m_req;
        bit    acc;
        bit    rv;
        bit    do_pop;
        pend_t p;
        cyc++;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        m_req = m_run && ((mq.size() + live) < DEPTH);
        if (started) begin
            chk("req", {31'd0, imem_req}, {31'd0, m_req});
            if (m_req) chk("addr", imem_addr, m_fetch_pc);
            chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
            chk("count", {29'd0, count}, mq.size());
            if (mq.size() != 0) begin
                chk("head_pc", pc, mq[0].pc);
                chk("head_instr", instr, mq[0].instr);
            end
        end
        gnt    = gnt_en && imem_req;
        rv     = (pend.size() != 0) && (pend[0].due <= cyc);
        rvalid = rv;
        rdata  = rv ? memf(pend[0].addr) : 32'd0;
        acc    = gnt;
        if (rst) begin
            pend.delete(); mq.delete(); grant_log.delete(); pop_log.delete();
            m_run = 1'b0; m_fetch_pc = RESET_PC; m_resp_pc = RESET_PC;
            epoch++; grants = 0; stale_cnt = 0; started = 1'b1;
        end else begin
            if (rv) p = pend.pop_front();
            if (acc) begin
                pend.push_back('{imem_addr, epoch, cyc + lat});
                grants++;
                grant_log.push_back(imem_addr);
            end
            if (redirect) begin
                epoch++;
                mq.delete();
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
                m_resp_pc  = {redirect_pc[31:2], 2'b00};
                stale_cnt  = 0;
            end else begin
                if (acc) m_fetch_pc = m_fetch_pc + 32'd4;
                do_pop = (mq.size() != 0) && ready;
                if (do_pop) begin
                    pop_log.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (rv) begin
                    if (p.epoch == epoch) begin
                        mq.push_back('{m_resp_pc, memf(p.addr)});
                        m_resp_pc = m_resp_pc + 32'd4;
                    end else begin
                        stale_cnt++;
                    end
                end
                if (!m_run && enable) m_run = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stim
        int k;
        int n0;
        ready = 1'b1;
        do_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Streaming from RESET_PC with address wrap, no bubbles once filled
        lat = 2; gnt_en = 1'b1; ready = 1'b1; enable = 1'b1;
        k = 0;
        while (pop_log.size() < 1 && k < 40) begin @(posedge clk); #1; k++; end
        chk("t1_first_pop_timeout", {31'd0, pop_log.size() >= 1}, 32'd1);
        n0 = pop_log.size();
        repeat (10) @(posedge clk);
        #1;
        chk("t1_no_bubbles", pop_log.size() - n0, 32'd10);
        chk("t1_addr0", grant_log[0], 32'hFFFF_FFF8);
        chk("t1_addr1", grant_log[1], 32'hFFFF_FFFC);
        chk("t1_addr2", grant_log[2], 32'h0000_0000);
        chk("t1_addr3", grant_log[3], 32'h0000_0004);
        chk("t1_addr4", grant_log[4], 32'h0000_0008);
        chk("t1_pc0", pop_log[0], 32'hFFFF_FFF8);
        chk("t1_pc1", pop_log[1], 32'hFFFF_FFFC);
        chk("t1_pc2", pop_log[2], 32'h0000_0000);

        // Redirect while idle, then fill with ready low
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        @(posedge clk); #1;
        redirect = 1'b0; enable = 1'b1; ready = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t2_grants", grants, 32'd4);
        chk("t2_count_full", {29'd0, count}, 32'd4);
        chk("t2_req_off", {31'd0, imem_req}, 32'd0);
        chk("t2_first_addr", grant_log[0], 32'h0000_0040);
        chk("t2_last_addr", grant_log[3], 32'h0000_004C);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("t2_count_after_pop", {29'd0, count}, 32'd3);
        chk("t2_req_back", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        chk("t2_grants_after", grants, 32'd5);
        chk("t2_new_addr", grant_log[4], 32'h0000_0050);

        // Redirect with three requests in flight
        do_reset();
        lat = 4; ready = 1'b1; enable = 1'b1;
        k = 0;
        while (grants < 3 && k < 40) begin @(posedge clk); #1; k++; end
        chk("t3_grants", grants, 32'd3);
        gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(posedge clk); #1;
        redirect = 1'b0; gnt_en = 1'b1;
        chk("t3_count_flush", {29'd0, count}, 32'd0);
        k = 0;
        while (pop_log.size() < 1 && k < 60) begin @(posedge clk); #1; k++; end
        chk("t3_first_pc", pop_log[0], 32'h0000_0100);
        chk("t3_stale", stale_cnt, 32'd3);

        // Redirect coinciding with both a grant and a response
        do_reset();
        lat = 2; ready = 1'b1; enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n0 = pop_log.size();
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        @(posedge clk); #1;
        redirect = 1'b0;
        k = 0;
        while (pop_log.size() <= n0 && k < 60) begin @(posedge clk); #1; k++; end
        chk("t4_first_pc", pop_log[n0], 32'h0000_2000);
        chk("t4_stale", stale_cnt, 32'd2);

        // Reset asserted with two entries queued
        do_reset();
        lat = 2; ready = 1'b0; enable = 1'b1;
        k = 0;
        while (mq.size() < 2 && k < 40) begin @(posedge clk); #1; k++; end
        chk("t6_count_before", {29'd0, count}, 32'd2);
        rst = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        chk("t6_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_req", {31'd0, imem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
